// File: rtl/register_file_pkg.sv
// Shared defaults for the decode-stage register file.
package register_file_pkg;

    localparam int unsigned DefaultNRegs  = 32;
    localparam int unsigned DefaultRWidth = 32;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: x0 squash, write-to-read bypass and output register.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned R_WIDTH = DefaultRWidth,
    parameter int unsigned W_ADDR  = $clog2(DefaultNRegs)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               read,
    input  logic [W_ADDR-1:0]  addr,
    input  logic               forward,
    input  logic               wr_en,
    input  logic [W_ADDR-1:0]  wr_addr,
    input  logic [R_WIDTH-1:0] wr_data,
    input  logic [R_WIDTH-1:0] mem_data,
    output logic [R_WIDTH-1:0] data_out
);

    logic [R_WIDTH-1:0] data_d;
    logic [R_WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (read) begin
            // x0 wins over a matching bypass
            if (addr == '0) begin
                data_d = '0;
            end else if (forward && wr_en && (wr_addr == addr)) begin
                data_d = wr_data;
            end else begin
                data_d = mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/register_file.sv
// RV32 register file: one write port, two registered read ports with optional bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned N_REGS  = DefaultNRegs,
    parameter int unsigned R_WIDTH = DefaultRWidth,
    localparam int unsigned W_ADDR = $clog2(N_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rs0_write,
    input  logic [R_WIDTH-1:0] rs0_data_in,
    input  logic [W_ADDR-1:0]  rs0_addr,
    input  logic               rs1_read,
    input  logic [W_ADDR-1:0]  rs1_addr,
    input  logic               rs1_forward,
    output logic [R_WIDTH-1:0] rs1_data_out,
    input  logic               rs2_read,
    input  logic [W_ADDR-1:0]  rs2_addr,
    input  logic               rs2_forward,
    output logic [R_WIDTH-1:0] rs2_data_out
);

    logic [R_WIDTH-1:0] mem_q [N_REGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (rs0_write && (rs0_addr != '0)) begin
            mem_q[rs0_addr] <= rs0_data_in;
        end
    end

    rf_read_port #(
        .R_WIDTH (R_WIDTH),
        .W_ADDR  (W_ADDR)
    ) u_port1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .read     (rs1_read),
        .addr     (rs1_addr),
        .forward  (rs1_forward),
        .wr_en    (rs0_write),
        .wr_addr  (rs0_addr),
        .wr_data  (rs0_data_in),
        .mem_data (mem_q[rs1_addr]),
        .data_out (rs1_data_out)
    );

    rf_read_port #(
        .R_WIDTH (R_WIDTH),
        .W_ADDR  (W_ADDR)
    ) u_port2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .read     (rs2_read),
        .addr     (rs2_addr),
        .forward  (rs2_forward),
        .wr_en    (rs0_write),
        .wr_addr  (rs0_addr),
        .wr_data  (rs0_data_in),
        .mem_data (mem_q[rs2_addr]),
        .data_out (rs2_data_out)
    );

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        rs0_write;
    logic [31:0] rs0_data_in;
    logic [4:0]  rs0_addr;
    logic        rs1_read;
    logic [4:0]  rs1_addr;
    logic        rs1_forward;
    logic [31:0] rs1_data_out;
    logic        rs2_read;
    logic [4:0]  rs2_addr;
    logic        rs2_forward;
    logic [31:0] rs2_data_out;

    register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs0_write    (rs0_write),
        .rs0_data_in  (rs0_data_in),
        .rs0_addr     (rs0_addr),
        .rs1_read     (rs1_read),
        .rs1_addr     (rs1_addr),
        .rs1_forward  (rs1_forward),
        .rs1_data_out (rs1_data_out),
        .rs2_read     (rs2_read),
        .rs2_addr     (rs2_addr),
        .rs2_forward  (rs2_forward),
        .rs2_data_out (rs2_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ref_mem [32];
    logic [31:0] exp1;
    logic [31:0] exp2;
    int unsigned n_checks;
    int unsigned n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h", tag, got, want);
        end
    endtask

    // Expected read result for one port, using memory contents before the edge.
    function automatic logic [31:0] model_read(input logic [4:0] a, input bit fwd, input bit w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (fwd && w && (wa == a)) return wd;
        return ref_mem[a];
    endfunction

    // Drive one cycle, advance the model, then check both outputs just after the edge.
    task automatic do_cycle(input string tag, input bit rst, input bit w, input logic [4:0] wa,
                            input logic [31:0] wd, input bit r1, input logic [4:0] a1,
                            input bit f1, input bit r2, input logic [4:0] a2, input bit f2);
        rst_n       = ~rst;
        rs0_write   = w;
        rs0_addr    = wa;
        rs0_data_in = wd;
        rs1_read    = r1;
        rs1_addr    = a1;
        rs1_forward = f1;
        rs2_read    = r2;
        rs2_addr    = a2;
        rs2_forward = f2;
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
            exp1 = 32'h0;
            exp2 = 32'h0;
        end else begin
            if (r1) exp1 = model_read(a1, f1, w, wa, wd);
            if (r2) exp2 = model_read(a2, f2, w, wa, wd);
            if (w && wa != 5'd0) ref_mem[wa] = wd;
        end
        @(posedge clk);
        #1;
        check({tag, ".p1"}, rs1_data_out, exp1);
        check({tag, ".p2"}, rs2_data_out, exp2);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'hxxxx_xxxx;
        exp1 = 32'h0;
        exp2 = 32'h0;
        #1;

        do_cycle("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            do_cycle("reset_read", 0, 0, 0, 0, 1, 5'(i), 0, 1, 5'(i), 0);

        for (int i = 0; i < 32; i++)
            do_cycle("fill_wr", 0, 1, 5'(i), 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            do_cycle("fill_rd1", 0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            do_cycle("fill_rd2", 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0);

        for (int i = 0; i < 32; i++)
            do_cycle("dist_wr", 0, 1, 5'(i), 32'h1000 + i, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            do_cycle("dist_rd", 0, 0, 0, 0, 1, 5'(i), 0, 1, 5'(31 - i), 0);

        do_cycle("byp_setup", 0, 1, 5, 32'hAAAA0000, 0, 0, 0, 0, 0, 0);
        do_cycle("bypass", 0, 1, 5, 32'h12345678, 1, 5, 1, 1, 5, 0);
        check("bypass_fwd", rs1_data_out, 32'h12345678);
        check("bypass_nofwd", rs2_data_out, 32'hAAAA0000);
        do_cycle("byp_after", 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        check("bypass_later", rs2_data_out, 32'h12345678);

        do_cycle("hold_setup", 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        do_cycle("hold_read", 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            do_cycle("hold", 0, 1, 7, 32'h0BAD_0000 + i, 0, 7, 1, 0, 0, 0);
        check("hold_value", rs1_data_out, 32'hDEADBEEF);
        do_cycle("x0_fwd", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 1, 0, 1);
        do_cycle("x0_read", 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);

        do_cycle("mid_pre", 0, 0, 0, 0, 1, 7, 0, 1, 5, 0);
        do_cycle("mid_rst", 1, 1, 3, 32'h55, 1, 3, 1, 1, 3, 1);
        do_cycle("mid_read", 0, 0, 0, 0, 1, 3, 0, 1, 3, 0);
        check("mid_rst_addr3", rs1_data_out, 32'h0);

        for (int n = 0; n < 600; n++) begin
            bit          narrow;
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            narrow = ($urandom_range(0, 1) == 1);
            wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            do_cycle("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), wa,
                     $urandom, ($urandom_range(0, 3) != 0), a1, ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 3) != 0), a2, ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
